cdc_tx_arbiter: RTL and testbench

CDC_TX_ARBITER -- requirements
Module: cdc_tx_arbiter

---
 rtl/cdc_tx_arbiter_pkg.sv | 19 +
 rtl/cdc_tx_arbiter_rr_arbiter.sv | 43 ++++
 rtl/cdc_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_cdc_tx_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_tx_arbiter_pkg.sv
// Shared definitions for the CDC transmit arbiter.
// Holds the FSM state encoding, the default acknowledge timeout,
// and a helper that sizes requester index fields.
package cdc_tx_arbiter_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SEND    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // Default number of CLK cycles to wait for acknowledge assertion
    localparam int DEFAULT_TIMEOUT = 255;

    // Width of an index into n requesters (at least one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdc_tx_arbiter_rr_arbiter.sv
// Round-robin requester selection (combinational).
// Ports:
//   req_i   - request vector, one bit per requester
//   ptr_i   - index where the search starts (highest priority this cycle)
//   grant_o - one-hot grant of the selected requester, zero if no request
//   index_o - index of the selected requester, zero if no request
module rr_arbiter
    import cdc_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   index_o
);

    // Candidate order: ptr, ptr+1, ... wrapping at NUM_REQ
    logic [IDX_W-1:0] cand [NUM_REQ];
    logic             found;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand[gi] = IDX_W'((32'(ptr_i) + gi) % NUM_REQ);
        end
    endgenerate

    // First requesting candidate in rotated order wins
    always_comb begin
        grant_o = '0;
        index_o = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_i[cand[k]]) begin
                found             = 1'b1;
                index_o           = cand[k];
                grant_o[cand[k]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdc_tx_arbiter.sv
// Shares one synchronized bus channel among NUM_REQ source-domain requesters.
// A granted word is held on UN_SYNC_BUS with BUS_EN raised until the
// destination acknowledge (synchronized through NUM_STAGES flops) is seen,
// then the block waits for the acknowledge to drop before the next grant.
// Ports:
//   CLK, RST     - source clock, asynchronous active-low reset
//   REQ          - level requests, held until granted
//   REQ_DATA     - requester i's word at [i*BUS_WIDTH +: BUS_WIDTH]
//   GNT          - one-hot, one-cycle grant pulse (word captured)
//   ACK_ASYNC    - destination acknowledge, asynchronous to CLK
//   BUS_EN       - enable to the destination data synchronizer (registered)
//   UN_SYNC_BUS  - captured word (registered)
//   BUSY         - high whenever the FSM is not idle
//   ERR          - one-cycle pulse on acknowledge timeout
module cdc_tx_arbiter
    import cdc_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_REQ-1:0]           REQ,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]           GNT,
    input  logic                         ACK_ASYNC,
    output logic                         BUS_EN,
    output logic [BUS_WIDTH-1:0]         UN_SYNC_BUS,
    output logic                         BUSY,
    output logic                         ERR
);

    localparam int IDX_W   = idx_width(NUM_REQ);
    localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // ERR fires on the edge where the counter would reach TIMEOUT
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    logic [1:0]            state_q,  state_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [IDX_W-1:0]      ptr_q,    ptr_d;
    logic [BUS_WIDTH-1:0]  data_q,   data_d;
    logic [NUM_REQ-1:0]    gnt_q,    gnt_d;
    logic                  bus_en_q, bus_en_d;
    logic                  err_q,    err_d;
    logic [NUM_STAGES-1:0] ack_sync_q, ack_sync_d;

    logic                  ack_s;
    logic [NUM_REQ-1:0]    arb_grant;
    logic [IDX_W-1:0]      arb_idx;
    logic [BUS_WIDTH-1:0]  sel_word;
    logic                  timeout_hit;

    // Acknowledge synchronizer chain; only the last stage is used
    assign ack_sync_d[0] = ACK_ASYNC;
    generate
        for (genvar gi = 1; gi < NUM_STAGES; gi++) begin : g_sync
            assign ack_sync_d[gi] = ack_sync_q[gi-1];
        end
    endgenerate
    assign ack_s = ack_sync_q[NUM_STAGES-1];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i   (REQ),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .index_o (arb_idx)
    );

    assign sel_word    = REQ_DATA[arb_idx*BUS_WIDTH +: BUS_WIDTH];
    assign timeout_hit = (cnt_q >= CNT_W'(TO_LAST));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        data_d   = data_q;
        gnt_d    = '0;
        bus_en_d = bus_en_q;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|REQ) begin
                    data_d   = sel_word;
                    gnt_d    = arb_grant;
                    bus_en_d = 1'b1;
                    cnt_d    = '0;
                    // Next search starts just after the winner
                    ptr_d    = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ack_s) begin
                    bus_en_d = 1'b0;
                    state_d  = ST_RELEASE;
                end else begin
                    // Saturating count of cycles without acknowledge
                    if (cnt_q != CNT_W'(TIMEOUT)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (timeout_hit) begin
                        err_d    = 1'b1;
                        bus_en_d = 1'b0;
                        state_d  = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                // Wait for the destination to drop acknowledge; no timeout here
                if (!ack_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                bus_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            data_q     <= '0;
            gnt_q      <= '0;
            bus_en_q   <= 1'b0;
            err_q      <= 1'b0;
            ack_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            data_q     <= data_d;
            gnt_q      <= gnt_d;
            bus_en_q   <= bus_en_d;
            err_q      <= err_d;
            ack_sync_q <= ack_sync_d;
        end
    end

    assign GNT         = gnt_q;
    assign BUS_EN      = bus_en_q;
    assign UN_SYNC_BUS = data_q;
    assign ERR         = err_q;
    assign BUSY        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Self-checking bench for cdc_tx_arbiter: directed steps with a grant
// scoreboard (expected requester/word pushed at stimulus, popped on GNT).
module tb_cdc_tx_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int BUS_WIDTH  = 8;
    localparam int NUM_STAGES = 2;
    localparam int TIMEOUT    = 255;
    localparam int LOOP_DLY   = 3;
    // Cycles BUS_EN stays high with looped-back ack, and grant-to-IDLE time
    localparam int EN_CYC     = LOOP_DLY + NUM_STAGES + 1;
    localparam int XFER       = 2 * EN_CYC;

    logic                         CLK = 1'b0;
    logic                         RST = 1'b1;
    logic [NUM_REQ-1:0]           REQ = '0;
    logic [NUM_REQ*BUS_WIDTH-1:0] REQ_DATA = '0;
    logic [NUM_REQ-1:0]           GNT;
    logic                         ACK_ASYNC;
    logic                         BUS_EN;
    logic [BUS_WIDTH-1:0]         UN_SYNC_BUS;
    logic                         BUSY;
    logic                         ERR;

    logic                auto_ack   = 1'b0;
    logic                ack_manual = 1'b0;
    logic [LOOP_DLY-1:0] bus_en_dly = '0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [NUM_REQ-1:0]   gnt;
        logic [BUS_WIDTH-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    cdc_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .BUS_WIDTH  (BUS_WIDTH),
        .NUM_STAGES (NUM_STAGES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .REQ         (REQ),
        .REQ_DATA    (REQ_DATA),
        .GNT         (GNT),
        .ACK_ASYNC   (ACK_ASYNC),
        .BUS_EN      (BUS_EN),
        .UN_SYNC_BUS (UN_SYNC_BUS),
        .BUSY        (BUSY),
        .ERR         (ERR)
    );

    always #5 CLK = ~CLK;

    // Destination model: acknowledge follows BUS_EN after LOOP_DLY cycles
    always @(posedge CLK) bus_en_dly <= {bus_en_dly[LOOP_DLY-2:0], BUS_EN};
    assign ACK_ASYNC = auto_ack ? bus_en_dly[LOOP_DLY-1] : ack_manual;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int i, input logic [BUS_WIDTH-1:0] w);
        REQ_DATA[i*BUS_WIDTH +: BUS_WIDTH] = w;
    endtask

    task automatic expect_grant(input int i, input logic [BUS_WIDTH-1:0] w);
        exp_t e;
        e.gnt  = NUM_REQ'(1) << i;
        e.data = w;
        exp_q.push_back(e);
    endtask

    // Returns at the negedge where GNT is seen; waited = negedges elapsed
    task automatic wait_gnt(input int budget, input string tag, output int waited);
        waited = 0;
        while (waited < budget) begin
            @(negedge CLK);
            waited++;
            if (GNT != '0) break;
        end
        check(tag, 32'(GNT != '0), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int w;
        w = 0;
        while (BUSY && w < budget) begin
            @(negedge CLK);
            w++;
        end
        check(tag, 32'(BUSY), 32'd0);
    endtask

    // Scoreboard: every grant pulse must match the next expected transaction
    always @(negedge CLK) begin
        if (RST && GNT != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_gnt", 32'(GNT), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("gnt_vector", 32'(GNT), 32'(e.gnt));
                check("gnt_word", 32'(UN_SYNC_BUS), 32'(e.data));
                $display("grant %b word 0x%02h at %0t", GNT, UN_SYNC_BUS, $time);
            end
        end
    end

    initial begin
        int w;
        int cnt_en, cnt_busy, n, g, busy_lo;
        logic stable, err_seen, en_ok;

        // ---- reset state ----
        #2 RST = 1'b0;
        #1;
        check("rst_bus_en", 32'(BUS_EN), 32'd0);
        check("rst_gnt", 32'(GNT), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_bus", 32'(UN_SYNC_BUS), 32'd0);
        repeat (3) @(negedge CLK);
        check("rst_hold_busy", 32'(BUSY), 32'd0);
        RST = 1'b1;
        auto_ack = 1'b1;
        @(negedge CLK);

        // ---- fairness: all requesting, order 0,1,2,3,0 ----
        for (int i = 0; i < NUM_REQ; i++) set_word(i, BUS_WIDTH'(8'hF0 + i));
        expect_grant(0, 8'hF0);
        expect_grant(1, 8'hF1);
        expect_grant(2, 8'hF2);
        expect_grant(3, 8'hF3);
        expect_grant(0, 8'hF0);
        REQ = 4'b1111;
        wait_gnt(10, "fair_first", w);
        for (int k = 1; k < 5; k++) begin
            wait_gnt(XFER + 10, "fair_next", w);
            check("fair_spacing", 32'(w), 32'(XFER + 1));
        end
        REQ = '0;
        wait_idle(XFER + 10, "fair_idle");

        // ---- single request, requester 2 ----
        set_word(2, 8'hA5);
        expect_grant(2, 8'hA5);
        REQ = 4'b0100;
        wait_gnt(10, "single_gnt", w);
        check("single_bus_en", 32'(BUS_EN), 32'd1);
        check("single_busy", 32'(BUSY), 32'd1);
        REQ = '0;
        cnt_en = 0; cnt_busy = 0; stable = 1'b1; err_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!BUSY) break;
            if (BUS_EN) cnt_en++;
            cnt_busy++;
            if (UN_SYNC_BUS !== 8'hA5) stable = 1'b0;
            if (ERR) err_seen = 1'b1;
            @(negedge CLK);
        end
        check("single_en_cycles", 32'(cnt_en), 32'(EN_CYC));
        check("single_busy_cycles", 32'(cnt_busy), 32'(XFER));
        check("single_stable", 32'(stable), 32'd1);
        check("single_idle_hold", 32'(UN_SYNC_BUS), 32'h0A5);
        check("single_no_err", 32'(err_seen), 32'd0);

        // ---- request arriving while busy; short-lived request dropped ----
        set_word(0, 8'h11);
        set_word(1, 8'h22);
        set_word(3, 8'h33);
        expect_grant(0, 8'h11);
        REQ = 4'b0001;
        wait_gnt(10, "busy_first_gnt", w);
        REQ = '0;
        stable = 1'b1;
        for (n = 1; n <= 60; n++) begin
            @(negedge CLK);
            if (GNT != '0) break;
            if (UN_SYNC_BUS !== 8'h11) stable = 1'b0;
            if (n == 1) begin
                REQ[1] = 1'b1;
                expect_grant(1, 8'h22);
            end
            if (n == 2) REQ[3] = 1'b1;
            if (n == 4) REQ[3] = 1'b0;
        end
        check("busy_regrant_cycle", 32'(n), 32'(XFER + 1));
        check("busy_data_stable", 32'(stable), 32'd1);
        REQ = '0;
        wait_idle(XFER + 10, "busy_idle");

        // ---- acknowledge timeout ----
        auto_ack = 1'b0;
        ack_manual = 1'b0;
        set_word(0, 8'h5A);
        expect_grant(0, 8'h5A);
        REQ = 4'b0001;
        wait_gnt(10, "to_gnt", w);
        REQ = '0;
        n = 0; en_ok = 1'b1;
        while (n < TIMEOUT + 20) begin
            @(negedge CLK);
            n++;
            if (ERR) break;
            if (!BUS_EN) en_ok = 1'b0;
        end
        check("to_err_delay", 32'(n), 32'(TIMEOUT));
        check("to_bus_en_off", 32'(BUS_EN), 32'd0);
        check("to_bus_en_held", 32'(en_ok), 32'd1);
        @(negedge CLK);
        check("to_err_pulse", 32'(ERR), 32'd0);
        check("to_idle", 32'(BUSY), 32'd0);

        // ---- stuck acknowledge across timeout ----
        set_word(0, 8'h77);
        set_word(1, 8'h99);
        expect_grant(0, 8'h77);
        REQ = 4'b0001;
        wait_gnt(10, "stuck_gnt", w);
        REQ = '0;
        n = 0;
        while (n < TIMEOUT + 20) begin
            @(negedge CLK);
            n++;
            if (ERR) break;
            if (n == TIMEOUT - NUM_STAGES) ack_manual = 1'b1;
        end
        check("stuck_err_delay", 32'(n), 32'(TIMEOUT));
        REQ = 4'b0010;
        busy_lo = 0; g = 0;
        repeat (20) begin
            @(negedge CLK);
            if (!BUSY) busy_lo++;
            if (GNT != '0) g++;
        end
        check("stuck_busy", 32'(busy_lo), 32'd0);
        check("stuck_no_gnt", 32'(g), 32'd0);
        check("stuck_bus_en", 32'(BUS_EN), 32'd0);
        expect_grant(1, 8'h99);
        ack_manual = 1'b0;
        auto_ack = 1'b1;
        wait_gnt(NUM_STAGES + 6, "stuck_release_gnt", w);
        REQ = '0;
        wait_idle(XFER + 10, "stuck_idle");

        // ---- reset mid-transfer ----
        set_word(2, 8'h3C);
        expect_grant(2, 8'h3C);
        REQ = 4'b0100;
        wait_gnt(10, "mid_gnt", w);
        REQ = '0;
        repeat (2) @(negedge CLK);
        check("mid_pre_bus", 32'(UN_SYNC_BUS), 32'h03C);
        check("mid_pre_en", 32'(BUS_EN), 32'd1);
        #2 RST = 1'b0;
        #1;
        check("mid_rst_bus_en", 32'(BUS_EN), 32'd0);
        check("mid_rst_bus", 32'(UN_SYNC_BUS), 32'd0);
        check("mid_rst_busy", 32'(BUSY), 32'd0);
        check("mid_rst_gnt", 32'(GNT), 32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (8) @(negedge CLK);
        // Pointer back at 0: requester 0 wins over 3, then 3 alone
        set_word(0, 8'hC0);
        set_word(3, 8'hC3);
        expect_grant(0, 8'hC0);
        expect_grant(3, 8'hC3);
        REQ = 4'b1001;
        wait_gnt(10, "post_rst_gnt0", w);
        REQ = 4'b1000;
        wait_gnt(XFER + 10, "post_rst_gnt3", w);
        REQ = '0;
        wait_idle(XFER + 10, "post_rst_idle");

        repeat (4) @(negedge CLK);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against any unbounded stall
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
